lsu_dccm_arb: RTL and testbench
===============================

// Module: lsu_dccm_arb
// PURPOSE
//  Arbiter/sequencer for the single-ported DCCM bank array. Shares the array between the LSU pipe (DC1 issue)
//  and DMA slave requests buffered in a DEPTH-entry FIFO. Drives dccm_wren/rden/addresses/wr_data to the
//  memory and returns tagged DMA read data one cycle after grant. A starvation counter bounds DMA wait time.
// PARAMETERS
//  DCCM_BITS    16  byte-address width of DCCM
//  FDATA_W      39  full data width (data+ECC) per bank access
//  TAG_W        3   DMA request tag width
//  DEPTH        2   DMA request FIFO entries (power of 2, >=2)
//  STARVE_MAX   7   cycles a pending DMA request may lose before forced grant (>=1)
// PORTS
//  clk              in   1          clock
//  rst              in   1          synchronous reset, active-high
//  lsu_freeze_dc3   in   1          pipe freeze; no new DCCM access issued while high
//  lsu_rden         in   1          LSU read request
//  lsu_wren         in   1          LSU write request
//  lsu_rd_addr_lo   in   DCCM_BITS  LSU read address, lo bank
//  lsu_rd_addr_hi   in   DCCM_BITS  LSU read address, hi bank (misaligned)
//  lsu_wr_addr      in   DCCM_BITS  LSU write address
//  lsu_wr_data      in   FDATA_W    LSU write data
//  lsu_stall        out  1          LSU request present but not granted this cycle
//  dma_req_valid    in   1          DMA request valid
//  dma_req_ready    out  1          FIFO can accept (registered, = count<DEPTH)
//  dma_req_write    in   1          1=write, 0=read
//  dma_req_addr     in   DCCM_BITS  DMA address (single-bank access)
//  dma_req_wdata    in   FDATA_W    DMA write data
//  dma_req_tag      in   TAG_W      DMA tag
//  dma_rsp_valid    out  1          DMA read data valid
//  dma_rsp_tag      out  TAG_W      tag of returned read
//  dma_rsp_rdata    out  FDATA_W    read data (= dccm_rd_data_lo in response cycle)
//  dccm_wren        out  1          to memory: write enable
//  dccm_rden        out  1          to memory: read enable
//  dccm_wr_addr     out  DCCM_BITS  to memory
//  dccm_rd_addr_lo  out  DCCM_BITS  to memory
//  dccm_rd_addr_hi  out  DCCM_BITS  to memory
//  dccm_wr_data     out  FDATA_W    to memory
//  dccm_rd_data_lo  in   FDATA_W    from memory, valid cycle after rden
// BEHAVIOUR
//  Reset: FIFO empty, starve_cnt=0, dma_rsp_valid=0, dma_req_ready=0 during rst, 1 first cycle after;
//   dccm_wren/rden=0, lsu_stall=0 while rst.
//  Enqueue when dma_req_valid&dma_req_ready; full FIFO deasserts ready next cycle; valid w/o ready ignored.
//  Grant each cycle (freeze=0): dma_win = fifo_nonempty & (starve_cnt==STARVE_MAX | ~(lsu_rden|lsu_wren)).
//   Else LSU wins if requesting. Freeze=1: no grant, starve_cnt holds, lsu_stall=0.
//  lsu_stall = (lsu_rden|lsu_wren) & dma_win & ~freeze. LSU must hold request while stalled.
//  lsu_rden&lsu_wren together: write issued, read stalled (lsu_stall=1) -- illegal in normal op.
//  LSU grant: pass-through of LSU addr/data/enables to dccm_* (combinational, zero latency).
//  DMA grant: pop head; write -> wren, wr_addr=addr; read -> rden, rd_addr_lo=rd_addr_hi=addr.
//  starve_cnt: +1 (saturate STARVE_MAX) when fifo nonempty & no DMA grant & ~freeze; 0 on DMA grant/empty.
//  DMA read response: dma_rsp_valid=1 exactly 1 cycle after grant, tag registered, rdata=dccm_rd_data_lo.
//   If freeze rises in the response cycle, response still returns (memory output held by clock gate).
//  Simultaneous enqueue+pop on full FIFO: pop frees slot, ready stays registered (no same-cycle refill).
//  Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  rst mid-operation: FIFO flushed, pending response dropped (dma_rsp_valid=0 next cycle).
// CONFIGURATION
//  LSU_DCCM_DMA_BYPASS_EN defined: if FIFO empty, no LSU request, ~freeze, dma_req_valid&ready, request
//   granted same cycle (not enqueued) -> read response 1 cycle after dma_req_valid.
//  Undefined: every DMA request enqueued first; earliest grant 1 cycle after acceptance (rsp at +2).
// TESTING
//  1 Idle, DMA read addr 0x0040 tag 5 -> rden at +1 (+0 bypass), rsp_valid/tag=5 next cycle w/ mem data.
//  2 LSU rden held continuously, one DMA write queued -> LSU wins 7 cycles, cycle 8 DMA wren, lsu_stall=1 once.
//  3 Push 3 DMA reqs back-to-back under LSU load, DEPTH=2 -> ready low after 2nd, 3rd held, all in order.
//  4 freeze=1 with FIFO nonempty 10 cycles -> no rden/wren, starve_cnt frozen, resumes same count after.
//  5 rst asserted with DMA read granted -> no dma_rsp_valid, FIFO empty, ready=0 then 1.
//  6 lsu_rden&lsu_wren both high -> dccm_wren=1, dccm_rden=0, lsu_stall=1.

Source files
------------

// File: rtl/lsu_dccm_arb_if.sv
// DMA slave port of the DCCM arbiter: request channel into the arbiter's
// request FIFO and tagged read-response channel back to the DMA engine.
//
// Request handshake: a request transfers on a rising clock edge where
// dma_req_valid and dma_req_ready are both high. dma_req_ready is registered.
// Valid without ready is ignored, and the master holds its request until it
// is accepted. The response channel has no back-pressure: dma_rsp_valid is
// high for exactly one cycle per granted DMA read.
interface lsu_dccm_arb_if #(
    parameter int DCCM_BITS = 16,
    parameter int FDATA_W   = 39,
    parameter int TAG_W     = 3
) ();
    logic                 dma_req_valid;
    logic                 dma_req_ready;
    logic                 dma_req_write;
    logic [DCCM_BITS-1:0] dma_req_addr;
    logic [FDATA_W-1:0]   dma_req_wdata;
    logic [TAG_W-1:0]     dma_req_tag;
    logic                 dma_rsp_valid;
    logic [TAG_W-1:0]     dma_rsp_tag;
    logic [FDATA_W-1:0]   dma_rsp_rdata;

    // DMA engine side
    modport master (
        output dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata, dma_req_tag,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_tag, dma_rsp_rdata
    );

    // Arbiter side
    modport slave (
        input  dma_req_valid, dma_req_write, dma_req_addr, dma_req_wdata, dma_req_tag,
        output dma_req_ready, dma_rsp_valid, dma_rsp_tag, dma_rsp_rdata
    );
endinterface

// File: rtl/lsu_dccm_arb.sv
// Arbiter/sequencer sharing the single-ported DCCM between the LSU pipe and
// buffered DMA requests. The LSU path is a zero-latency pass-through; DMA
// requests wait in a DEPTH-entry FIFO and win when the LSU is idle or when the
// starvation counter reaches STARVE_MAX. DMA reads return one cycle after grant.
// Optional feature: define LSU_DCCM_DMA_BYPASS_EN to grant a DMA request in
// its arrival cycle when the FIFO is empty and the LSU is idle.
module lsu_dccm_arb #(
    parameter int DCCM_BITS  = 16,
    parameter int FDATA_W    = 39,
    parameter int TAG_W      = 3,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_lsu_freeze_dc3,
    input  logic                 i_lsu_rden,
    input  logic                 i_lsu_wren,
    input  logic [DCCM_BITS-1:0] i_lsu_rd_addr_lo,
    input  logic [DCCM_BITS-1:0] i_lsu_rd_addr_hi,
    input  logic [DCCM_BITS-1:0] i_lsu_wr_addr,
    input  logic [FDATA_W-1:0]   i_lsu_wr_data,
    output logic                 o_lsu_stall,
    lsu_dccm_arb_if.slave        dma,
    output logic                 o_dccm_wren,
    output logic                 o_dccm_rden,
    output logic [DCCM_BITS-1:0] o_dccm_wr_addr,
    output logic [DCCM_BITS-1:0] o_dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0] o_dccm_rd_addr_hi,
    output logic [FDATA_W-1:0]   o_dccm_wr_data,
    input  logic [FDATA_W-1:0]   i_dccm_rd_data_lo
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic                 r_mem_write [DEPTH];
    logic [DCCM_BITS-1:0] r_mem_addr  [DEPTH];
    logic [FDATA_W-1:0]   r_mem_wdata [DEPTH];
    logic [TAG_W-1:0]     r_mem_tag   [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ready;
    logic [SC_W-1:0]      r_starve_cnt;
    logic                 r_rsp_valid;
    logic [TAG_W-1:0]     r_rsp_tag;

    logic                 w_lsu_req;
    logic                 w_nonempty;
    logic                 w_active;
    logic                 w_fifo_grant;
    logic                 w_byp_grant;
    logic                 w_dma_grant;
    logic                 w_dma_write;
    logic [DCCM_BITS-1:0] w_dma_addr;
    logic [FDATA_W-1:0]   w_dma_wdata;
    logic [TAG_W-1:0]     w_dma_tag;
    logic                 w_lsu_win;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count_next;

    assign w_lsu_req    = i_lsu_rden | i_lsu_wren;
    assign w_nonempty   = (r_count != '0);
    assign w_active     = ~rst & ~i_lsu_freeze_dc3;
    assign w_fifo_grant = w_active & w_nonempty &
                          ((r_starve_cnt == SC_W'(STARVE_MAX)) | ~w_lsu_req);

`ifdef LSU_DCCM_DMA_BYPASS_EN
    // An arriving request skips the FIFO when nothing else wants the array.
    assign w_byp_grant  = w_active & ~w_nonempty & ~w_lsu_req &
                          dma.dma_req_valid & r_ready;
`else
    assign w_byp_grant  = 1'b0;
`endif

    assign w_dma_grant  = w_fifo_grant | w_byp_grant;
    assign w_dma_write  = w_fifo_grant ? r_mem_write[r_rptr] : dma.dma_req_write;
    assign w_dma_addr   = w_fifo_grant ? r_mem_addr[r_rptr]  : dma.dma_req_addr;
    assign w_dma_wdata  = w_fifo_grant ? r_mem_wdata[r_rptr] : dma.dma_req_wdata;
    assign w_dma_tag    = w_fifo_grant ? r_mem_tag[r_rptr]   : dma.dma_req_tag;
    assign w_lsu_win    = w_active & w_lsu_req & ~w_dma_grant;

    assign w_push       = dma.dma_req_valid & r_ready & ~w_byp_grant;
    assign w_pop        = w_fifo_grant;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Memory-side mux: LSU passes straight through; a simultaneous rden+wren
    // issues only the write and stalls the read.
    assign o_dccm_wren       = w_lsu_win ? i_lsu_wren : (w_dma_grant & w_dma_write);
    assign o_dccm_rden       = w_lsu_win ? (i_lsu_rden & ~i_lsu_wren)
                                         : (w_dma_grant & ~w_dma_write);
    assign o_dccm_wr_addr    = w_dma_grant ? w_dma_addr  : i_lsu_wr_addr;
    assign o_dccm_rd_addr_lo = w_dma_grant ? w_dma_addr  : i_lsu_rd_addr_lo;
    assign o_dccm_rd_addr_hi = w_dma_grant ? w_dma_addr  : i_lsu_rd_addr_hi;
    assign o_dccm_wr_data    = w_dma_grant ? w_dma_wdata : i_lsu_wr_data;
    assign o_lsu_stall       = w_active & w_lsu_req &
                               (w_fifo_grant | (i_lsu_rden & i_lsu_wren));

    assign dma.dma_req_ready = r_ready;
    assign dma.dma_rsp_valid = r_rsp_valid;
    assign dma.dma_rsp_tag   = r_rsp_tag;
    assign dma.dma_rsp_rdata = i_dccm_rd_data_lo;

    // FIFO payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_write[r_wptr] <= dma.dma_req_write;
            r_mem_addr[r_wptr]  <= dma.dma_req_addr;
            r_mem_wdata[r_wptr] <= dma.dma_req_wdata;
            r_mem_tag[r_wptr]   <= dma.dma_req_tag;
        end
    end

    // FIFO pointers, occupancy and the registered ready seen by the DMA master.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_ready <= (w_count_next < CNT_W'(DEPTH));
        end
    end

    // Starvation counter: counts cycles a queued request loses, holds on freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!i_lsu_freeze_dc3) begin
            if (w_fifo_grant || !w_nonempty) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    // Read response marker one cycle after a DMA read grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= '0;
        end else begin
            r_rsp_valid <= w_dma_grant & ~w_dma_write;
            if (w_dma_grant && !w_dma_write) r_rsp_tag <= w_dma_tag;
        end
    end
endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed bench for lsu_dccm_arb: reset, DMA read latency, starvation bound,
// FIFO back-pressure and ordering, freeze, reset flush, and rden+wren conflict.
module tb_lsu_dccm_arb;
    logic        clk;
    logic        rst;
    logic        lsu_freeze_dc3;
    logic        lsu_rden;
    logic        lsu_wren;
    logic [15:0] lsu_rd_addr_lo;
    logic [15:0] lsu_rd_addr_hi;
    logic [15:0] lsu_wr_addr;
    logic [38:0] lsu_wr_data;
    logic        lsu_stall;
    logic        dccm_wren;
    logic        dccm_rden;
    logic [15:0] dccm_wr_addr;
    logic [15:0] dccm_rd_addr_lo;
    logic [15:0] dccm_rd_addr_hi;
    logic [38:0] dccm_wr_data;
    logic [38:0] mem_q;

    int n_tests;
    int n_fail;
    int waited;

    logic [2:0]  exp_tag_q[$];
    logic [38:0] exp_q[$];
    logic [2:0]  got_tag_q[$];
    logic [38:0] got_dat_q[$];

    lsu_dccm_arb_if #(.DCCM_BITS(16), .FDATA_W(39), .TAG_W(3)) dma_if ();

    lsu_dccm_arb #(
        .DCCM_BITS(16), .FDATA_W(39), .TAG_W(3), .DEPTH(2), .STARVE_MAX(7)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_lsu_freeze_dc3  (lsu_freeze_dc3),
        .i_lsu_rden        (lsu_rden),
        .i_lsu_wren        (lsu_wren),
        .i_lsu_rd_addr_lo  (lsu_rd_addr_lo),
        .i_lsu_rd_addr_hi  (lsu_rd_addr_hi),
        .i_lsu_wr_addr     (lsu_wr_addr),
        .i_lsu_wr_data     (lsu_wr_data),
        .o_lsu_stall       (lsu_stall),
        .dma               (dma_if.slave),
        .o_dccm_wren       (dccm_wren),
        .o_dccm_rden       (dccm_rden),
        .o_dccm_wr_addr    (dccm_wr_addr),
        .o_dccm_rd_addr_lo (dccm_rd_addr_lo),
        .o_dccm_rd_addr_hi (dccm_rd_addr_hi),
        .o_dccm_wr_data    (dccm_wr_data),
        .i_dccm_rd_data_lo (mem_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] mem_data(input logic [15:0] a);
        return {a, ~a, 7'h15};
    endfunction

    // Memory model: read data appears the cycle after rden.
    always @(posedge clk) begin
        if (rst) mem_q <= '0;
        else if (dccm_rden) mem_q <= mem_data(dccm_rd_addr_lo);
    end

    // Advance one cycle and log any DMA response visible in the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (dma_if.dma_rsp_valid === 1'b1) begin
            got_tag_q.push_back(dma_if.dma_rsp_tag);
            got_dat_q.push_back(dma_if.dma_rsp_rdata);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dma_drive(input logic v, input logic w, input logic [15:0] a,
                             input logic [38:0] d, input logic [2:0] t);
        dma_if.dma_req_valid = v;
        dma_if.dma_req_write = w;
        dma_if.dma_req_addr  = a;
        dma_if.dma_req_wdata = d;
        dma_if.dma_req_tag   = t;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; lsu_freeze_dc3 = 1'b0; lsu_rden = 1'b0; lsu_wren = 1'b0;
        lsu_rd_addr_lo = 16'h0100; lsu_rd_addr_hi = 16'h0104;
        lsu_wr_addr = 16'h0000; lsu_wr_data = '0;
        dma_drive(1'b0, 1'b0, 16'h0, 39'h0, 3'd0);

        // Reset state; LSU request present to exercise stall gating.
        tick(); tick();
        lsu_rden = 1'b1; #1;
        chk("rst_ready", dma_if.dma_req_ready, 0);
        chk("rst_wren", dccm_wren, 0);
        chk("rst_rden", dccm_rden, 0);
        chk("rst_stall", lsu_stall, 0);
        chk("rst_rsp_valid", dma_if.dma_rsp_valid, 0);
        lsu_rden = 1'b0; rst = 1'b0;
        tick(); #1;
        chk("post_rst_ready", dma_if.dma_req_ready, 1);
        chk("idle_rden", dccm_rden, 0);

        // T1: idle DMA read, addr 0x0040 tag 5.
        dma_drive(1'b1, 1'b0, 16'h0040, 39'h0, 3'd5); #1;
`ifdef LSU_DCCM_DMA_BYPASS_EN
        chk("t1_byp_rden", dccm_rden, 1);
        chk("t1_byp_addr", dccm_rd_addr_lo, 16'h0040);
        tick(); dma_if.dma_req_valid = 1'b0; #1;
`else
        chk("t1_no_rden_at_accept", dccm_rden, 0);
        tick(); dma_if.dma_req_valid = 1'b0; #1;
        chk("t1_rden", dccm_rden, 1);
        chk("t1_addr_lo", dccm_rd_addr_lo, 16'h0040);
        chk("t1_addr_hi", dccm_rd_addr_hi, 16'h0040);
        chk("t1_no_early_rsp", dma_if.dma_rsp_valid, 0);
        tick(); #1;
`endif
        chk("t1_rsp_valid", dma_if.dma_rsp_valid, 1);
        chk("t1_rsp_tag", dma_if.dma_rsp_tag, 3'd5);
        chk("t1_rsp_rdata", dma_if.dma_rsp_rdata, mem_data(16'h0040));
        tick(); #1;
        chk("t1_rsp_single", dma_if.dma_rsp_valid, 0);

        // T2: LSU read held, one DMA write queued: 7 LSU wins, then DMA.
        lsu_rden = 1'b1;
        dma_drive(1'b1, 1'b1, 16'h0200, 39'h12_3456_789A, 3'd1); #1;
        chk("t2_c0_rden", dccm_rden, 1);
        chk("t2_c0_addr", dccm_rd_addr_lo, 16'h0100);
        chk("t2_c0_stall", lsu_stall, 0);
        tick(); dma_if.dma_req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("t2_lsu_rden", dccm_rden, 1);
            chk("t2_lsu_wren", dccm_wren, 0);
            chk("t2_lsu_stall", lsu_stall, 0);
            tick();
        end
        #1;
        chk("t2_dma_wren", dccm_wren, 1);
        chk("t2_dma_rden", dccm_rden, 0);
        chk("t2_dma_waddr", dccm_wr_addr, 16'h0200);
        chk("t2_dma_wdata", dccm_wr_data, 39'h12_3456_789A);
        chk("t2_dma_stall", lsu_stall, 1);
        tick(); #1;
        chk("t2_after_rden", dccm_rden, 1);
        chk("t2_after_stall", lsu_stall, 0);
        chk("t2_write_no_rsp", dma_if.dma_rsp_valid, 0);

        // T3: three reads back-to-back under LSU load, DEPTH=2.
        got_tag_q.delete(); got_dat_q.delete();
        tick();
        dma_drive(1'b1, 1'b0, 16'h0010, 39'h0, 3'd2); #1;
        chk("t3_ready0", dma_if.dma_req_ready, 1);
        tick();
        dma_drive(1'b1, 1'b0, 16'h0020, 39'h0, 3'd3); #1;
        chk("t3_ready1", dma_if.dma_req_ready, 1);
        tick();
        dma_drive(1'b1, 1'b0, 16'h0030, 39'h0, 3'd4); #1;
        chk("t3_full_ready", dma_if.dma_req_ready, 0);
        waited = 0;
        while (dma_if.dma_req_ready !== 1'b1 && waited < 20) begin
            tick(); #1;
            waited++;
        end
        chk("t3_hold_cycles", waited, 7);
        tick();
        dma_if.dma_req_valid = 1'b0; lsu_rden = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        exp_tag_q = {3'd2, 3'd3, 3'd4};
        exp_q = {mem_data(16'h0010), mem_data(16'h0020), mem_data(16'h0030)};
        chk("t3_rsp_count", got_tag_q.size(), 3);
        while (exp_tag_q.size() > 0 && got_tag_q.size() > 0) begin
            chk("t3_rsp_tag", got_tag_q.pop_front(), exp_tag_q.pop_front());
            chk("t3_rsp_data", got_dat_q.pop_front(), exp_q.pop_front());
        end

        // T4: freeze for 10 cycles with a queued read; counter resumes at 3.
        lsu_rden = 1'b1;
        dma_drive(1'b1, 1'b0, 16'h0050, 39'h0, 3'd6); #1;
        tick(); dma_if.dma_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("t4_pre_rden", dccm_rden, 1); chk("t4_pre_stall", lsu_stall, 0);
            tick();
        end
        lsu_freeze_dc3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_frz_rden", dccm_rden, 0);
            chk("t4_frz_wren", dccm_wren, 0);
            chk("t4_frz_stall", lsu_stall, 0);
            tick();
        end
        lsu_freeze_dc3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_post_lsu_addr", dccm_rd_addr_lo, 16'h0100);
            chk("t4_post_stall", lsu_stall, 0);
            tick();
        end
        #1;
        chk("t4_grant_stall", lsu_stall, 1);
        chk("t4_grant_addr", dccm_rd_addr_lo, 16'h0050);
        tick(); lsu_rden = 1'b0; #1;
        chk("t4_rsp_valid", dma_if.dma_rsp_valid, 1);
        chk("t4_rsp_tag", dma_if.dma_rsp_tag, 3'd6);
        chk("t4_rsp_rdata", dma_if.dma_rsp_rdata, mem_data(16'h0050));

        // T5: reset in the cycle a queued DMA read would be granted.
        tick();
        lsu_rden = 1'b1;
        dma_drive(1'b1, 1'b0, 16'h0060, 39'h0, 3'd7); #1;
        tick();
        dma_drive(1'b1, 1'b0, 16'h0070, 39'h0, 3'd0); #1;
        chk("t5_ready", dma_if.dma_req_ready, 1);
        tick();
        dma_if.dma_req_valid = 1'b0; lsu_rden = 1'b0; rst = 1'b1; #1;
        chk("t5_rst_rden", dccm_rden, 0);
        chk("t5_rst_ready", dma_if.dma_req_ready, 0);
        tick(); #1;
        chk("t5_rsp_dropped", dma_if.dma_rsp_valid, 0);
        chk("t5_ready_low", dma_if.dma_req_ready, 0);
        rst = 1'b0;
        tick(); #1;
        chk("t5_ready_high", dma_if.dma_req_ready, 1);
        chk("t5_flushed_rden", dccm_rden, 0);
        tick(); #1;
        chk("t5_flushed_rden2", dccm_rden, 0);
        chk("t5_no_rsp", dma_if.dma_rsp_valid, 0);

        // T6: illegal rden+wren: write issued, read stalled.
        lsu_rden = 1'b1; lsu_wren = 1'b1;
        lsu_wr_addr = 16'h0300; lsu_wr_data = 39'h00_0000_007F; #1;
        chk("t6_wren", dccm_wren, 1);
        chk("t6_rden", dccm_rden, 0);
        chk("t6_stall", lsu_stall, 1);
        chk("t6_waddr", dccm_wr_addr, 16'h0300);
        chk("t6_wdata", dccm_wr_data, 39'h00_0000_007F);
        tick();
        lsu_rden = 1'b0; lsu_wren = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
